// File: rtl/bcd2bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one bit per clock.
// Accepts a packed BCD word via new_data/new_ack and presents an N-bit result with done.
module bcd2bin #(
  parameter int N = 16,
  parameter int M = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] data_in,
  input  logic         new_data,
  output logic         new_ack,
  output logic [N-1:0] data_out,
  output logic         done,
  output logic         bad_digit,
  output logic         overflow
);

  localparam int D  = M / 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [M-1:0]   bcd_reg;
  logic [N-1:0]   bin_reg;
  logic [CW-1:0]  cnt;

  logic [M-1:0]   bcd_step;
  logic [N-1:0]   bin_step;
  logic           accept;
  logic           last_step;
  logic           any_bad;

  // Per-digit correction after the right shift: digits >= 8 lose 3, no inter-digit carry.
  function automatic logic [M-1:0] fix_digits(input logic [M-1:0] v);
    logic [M-1:0] r;
    r = v;
    for (int unsigned i = 0; i < D; i++) begin
      if (v[4*i +: 4] >= 4'd8) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    bin_step = {bcd_reg[0], bin_reg[N-1:1]};
    bcd_step = fix_digits(bcd_reg >> 1);
  end

  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < D; i++) begin
      if (data_in[4*i +: 4] > 4'd9) begin
        any_bad = 1'b1;
      end
    end
  end

  assign accept    = new_data && new_ack;
  assign last_step = (state == BUSY) && (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (accept) state_next = BUSY;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    new_ack = (state != BUSY);
  end

  // Datapath; the residual left in bcd_reg after N steps is floor(value / 2^N).
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      data_out  <= '0;
      done      <= 1'b0;
      bad_digit <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      bcd_reg   <= data_in;
      bin_reg   <= '0;
      cnt       <= '0;
      bad_digit <= any_bad;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == BUSY) begin
      bcd_reg <= bcd_step;
      bin_reg <= bin_step;
      cnt     <= cnt + CW'(1);
      if (last_step) begin
        data_out <= bin_step;
        overflow <= |bcd_step;
        done     <= 1'b1;
      end
    end
  end

endmodule
